ifetch_queue: RTL and testbench

- Instruction fetch stage that sits directly upstream of the register bank and ALU.
- Owns the fetch program counter and runs a req/ack read handshake to instruction memory.
- Buffers returned words in a small prefetch queue.
- Presents the head instruction with pre-sliced register-select fields (rd/rs0/rs1) to the decode/execute control that drives the bank's sel/setd0/setd1.

---
 rtl/ifetch_queue_if.sv | 11 +
 rtl/ifetch_queue.sv | 161 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Instruction-memory read port: one request outstanding, completed by mem_ack.
// master = fetch unit, slave = instruction memory.
interface ifetch_queue_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch with prefetch queue: owns the fetch PC, issues req/ack reads and
// presents the head word with register-select fields. Optional IFETCH_ALIGN_CHK_EN adds fetch_fault.
module ifetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    ifetch_queue_if.master       mem,
    input  logic                 redirect,
    input  logic [15:0]          redirect_addr,
    output logic                 ir_valid,
    input  logic                 ir_ready,
    output logic [15:0]          ir_data,
    output logic [15:0]          ir_pc,
    output logic [3:0]           opcode,
    output logic [2:0]           rd_sel,
    output logic [2:0]           rs0_sel,
    output logic [2:0]           rs1_sel,
    output logic [15:0]          fetch_pc
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    output logic                 fetch_fault
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;

    state_t          state;
    logic [15:0]     q_data [DEPTH];
    logic [15:0]     q_pc   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic            push, pop, has_head, has_room, fault_redirect;
    logic [15:0]     redir_pc, drain_pc;

    function automatic logic [15:0] pc_inc(input logic [15:0] a);
        return a + 16'd2;
    endfunction

    assign redir_pc   = redirect_addr & ~16'h0001;
    assign drain_pc   = redirect ? redir_pc : fetch_pc;
    assign has_head   = (count != '0);
    assign ir_valid   = has_head & en;
    // A redirect flushes the queue, so a coincident pop must not move rd_ptr.
    assign pop        = ir_valid & ir_ready & ~redirect;
    assign push       = (state == REQ) & mem.mem_ack & ~redirect;
    assign count_next = count + CW'(push) - CW'(pop);
    assign has_room   = (count_next < CW'(DEPTH));

`ifdef IFETCH_ALIGN_CHK_EN
    assign fault_redirect = redirect & redirect_addr[0] & (state != HALT);
`else
    assign fault_redirect = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= RESET_PC;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
`ifdef IFETCH_ALIGN_CHK_EN
            fetch_fault  <= 1'b0;
`endif
        end else begin
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (redirect) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end

            if (fault_redirect) begin
                // Any request in flight must still complete before the port goes quiet.
                state       <= HALT;
                mem.mem_req <= mem.mem_req & ~mem.mem_ack;
`ifdef IFETCH_ALIGN_CHK_EN
                fetch_fault <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (redirect) begin
                            fetch_pc <= redir_pc;
                            if (en) begin
                                state        <= REQ;
                                mem.mem_req  <= 1'b1;
                                mem.mem_addr <= redir_pc;
                            end
                        end else if (en && (count < CW'(DEPTH))) begin
                            state        <= REQ;
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= fetch_pc;
                        end
                    end
                    REQ: begin
                        if (redirect) begin
                            fetch_pc <= redir_pc;
                            if (!mem.mem_ack) begin
                                state <= DRAIN;
                            end else if (en) begin
                                mem.mem_addr <= redir_pc;
                            end else begin
                                state       <= IDLE;
                                mem.mem_req <= 1'b0;
                            end
                        end else if (mem.mem_ack) begin
                            fetch_pc <= pc_inc(fetch_pc);
                            if (en && has_room) begin
                                mem.mem_addr <= pc_inc(fetch_pc);
                            end else begin
                                state       <= IDLE;
                                mem.mem_req <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (redirect) fetch_pc <= redir_pc;
                        if (mem.mem_ack) begin
                            if (en) begin
                                state        <= REQ;
                                mem.mem_addr <= drain_pc;
                            end else begin
                                state       <= IDLE;
                                mem.mem_req <= 1'b0;
                            end
                        end
                    end
                    HALT: begin
                        if (mem.mem_ack) mem.mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= mem.mem_rdata;
            q_pc[wr_ptr]   <= fetch_pc;
        end
    end

    assign ir_data = has_head ? q_data[rd_ptr] : 16'h0000;
    assign ir_pc   = has_head ? q_pc[rd_ptr]   : 16'h0000;
    assign opcode  = ir_data[15:12];
    assign rd_sel  = ir_data[11:9];
    assign rs0_sel = ir_data[8:6];
    assign rs1_sel = ir_data[5:3];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a cycle table plus hand sequences for
// backpressure, delayed-ack redirect, redirect-with-ack, PC wrap and (if enabled) alignment fault.
module tb_ifetch_queue;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT 0: default parameters, memory data = addr ^ A5A5 with programmable ack latency
    logic        en0, rdy0, redir0, vld0;
    logic [15:0] raddr0, data0, pc0, fpc0;
    logic [3:0]  op0;
    logic [2:0]  rd0, rs00, rs10;
    int          lat0;
    logic [2:0]  wcnt0;
    ifetch_queue_if m0();

    always_ff @(posedge clk)
        if (!rst || !m0.mem_req || m0.mem_ack) wcnt0 <= 3'd0;
        else                                   wcnt0 <= wcnt0 + 3'd1;
    assign m0.mem_ack   = m0.mem_req && (int'(wcnt0) >= lat0);
    assign m0.mem_rdata = m0.mem_addr ^ 16'hA5A5;

`ifdef IFETCH_ALIGN_CHK_EN
    logic fault0;
`endif

    ifetch_queue dut0 (
        .clk(clk), .rst(rst), .en(en0), .mem(m0),
        .redirect(redir0), .redirect_addr(raddr0),
        .ir_valid(vld0), .ir_ready(rdy0), .ir_data(data0), .ir_pc(pc0),
        .opcode(op0), .rd_sel(rd0), .rs0_sel(rs00), .rs1_sel(rs10),
        .fetch_pc(fpc0)
`ifdef IFETCH_ALIGN_CHK_EN
        , .fetch_fault(fault0)
`endif
    );

    // DUT 1: reset PC near the top of the address space, zero-wait memory = addr ^ C5AC
    logic        en1, rdy1, redir1, vld1;
    logic [15:0] raddr1, data1, pc1, fpc1;
    logic [3:0]  op1;
    logic [2:0]  rd1, rs01, rs11;
    ifetch_queue_if m1();
    assign m1.mem_ack   = m1.mem_req;
    assign m1.mem_rdata = m1.mem_addr ^ 16'hC5AC;

`ifdef IFETCH_ALIGN_CHK_EN
    logic fault1;
`endif

    ifetch_queue #(.DEPTH(2), .RESET_PC(16'hFFFC)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .mem(m1),
        .redirect(redir1), .redirect_addr(raddr1),
        .ir_valid(vld1), .ir_ready(rdy1), .ir_data(data1), .ir_pc(pc1),
        .opcode(op1), .rd_sel(rd1), .rs0_sel(rs01), .rs1_sel(rs11),
        .fetch_pc(fpc1)
`ifdef IFETCH_ALIGN_CHK_EN
        , .fetch_fault(fault1)
`endif
    );

    typedef struct {
        logic        en;
        logic        rdy;
        logic        ereq;
        logic [15:0] eaddr;
        logic        evld;
        logic [15:0] epc;
        logic [15:0] edata;
        logic [15:0] efpc;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en0 = 1'b0; rdy0 = 1'b0; redir0 = 1'b0; raddr0 = 16'h0000; lat0 = 0;
        en1 = 1'b0; rdy1 = 1'b0; redir1 = 1'b0; raddr1 = 16'h0000;
        tick();
        tick();
        chk("rst_req0",   16'(m0.mem_req), 16'h0000);
        chk("rst_addr0",  m0.mem_addr,     16'h0000);
        chk("rst_vld0",   16'(vld0),       16'h0000);
        chk("rst_data0",  data0,           16'h0000);
        chk("rst_pc0",    pc0,             16'h0000);
        chk("rst_fpc0",   fpc0,            16'h0000);
        chk("rst_fields0", {op0, rd0, rs00, rs10, 3'b000}, 16'h0000);
        chk("rst_addr1",  m1.mem_addr,     16'hFFFC);
        chk("rst_fpc1",   fpc1,            16'hFFFC);
`ifdef IFETCH_ALIGN_CHK_EN
        chk("rst_fault0", 16'(fault0),     16'h0000);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int req_cycles;

        //        en  rdy req addr      vld pc        data      fetch_pc
        tbl[0] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hA5A5, 16'h0002};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'hA5A7, 16'h0004};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'hA5A1, 16'h0006};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0008};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'hA5A1, 16'h0008};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'hA5A3, 16'h0008};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000, 16'h0008};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 16'h000A, 1'b1, 16'h0008, 16'hA5AD, 16'h000A};

        // Streaming with enable/ready variations
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            en0  = tbl[i].en;
            rdy0 = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d_req", i), 16'(m0.mem_req), 16'(tbl[i].ereq));
            if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), m0.mem_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d_vld", i), 16'(vld0), 16'(tbl[i].evld));
            if (tbl[i].evld) begin
                chk($sformatf("tbl%0d_pc", i),   pc0,   tbl[i].epc);
                chk($sformatf("tbl%0d_data", i), data0, tbl[i].edata);
            end
            chk($sformatf("tbl%0d_fpc", i), fpc0, tbl[i].efpc);
        end

        // Backpressure: exactly DEPTH pushes, then one pop allows a single new request
        do_reset();
        rst = 1'b1; en0 = 1'b1; rdy0 = 1'b0;
        tick(); tick(); tick();
        chk("bp_req_full",  16'(m0.mem_req), 16'h0000);
        chk("bp_fpc_full",  fpc0,            16'h0004);
        chk("bp_head_pc",   pc0,             16'h0000);
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (m0.mem_req) req_cycles++;
        end
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        chk("bp_pop_pc", pc0, 16'h0002);
        if (m0.mem_req) req_cycles++;
        tick();
        chk("bp_req_new",  16'(m0.mem_req), 16'h0001);
        chk("bp_addr_new", m0.mem_addr,     16'h0004);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m0.mem_req) req_cycles++;
        end
        chk("bp_extra_req_cycles", 16'(req_cycles), 16'h0000);
        chk("bp_fpc_after", fpc0, 16'h0006);
        chk("bp_vld_after", 16'(vld0), 16'h0001);

        // Redirect during a 3-cycle wait: old address held, its word dropped
        do_reset();
        rst = 1'b1; en0 = 1'b1; rdy0 = 1'b1; lat0 = 3;
        tick();
        redir0 = 1'b1; raddr0 = 16'h0100;
        tick();
        redir0 = 1'b0;
        chk("dr_fpc", fpc0, 16'h0100);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dr_hold%0d_req", i),  16'(m0.mem_req), 16'h0001);
            chk($sformatf("dr_hold%0d_addr", i), m0.mem_addr,     16'h0000);
            tick();
        end
        chk("dr_new_req",  16'(m0.mem_req), 16'h0001);
        chk("dr_new_addr", m0.mem_addr,     16'h0100);
        chk("dr_new_vld",  16'(vld0),       16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (vld0) begin
                seen = 1'b1;
                chk("dr_first_pc",   pc0,   16'h0100);
                chk("dr_first_data", data0, 16'hA4A5);
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL dr_timeout: got no ir_valid expected ir_valid within 20 cycles");
        end

        // Redirect coincident with mem_ack (and a pop): flush, drop word, refetch
        do_reset();
        rst = 1'b1; en0 = 1'b1; rdy0 = 1'b0; lat0 = 0;
        tick(); tick();
        chk("ra_pre_vld",  16'(vld0), 16'h0001);
        chk("ra_pre_ack",  16'(m0.mem_ack), 16'h0001);
        redir0 = 1'b1; raddr0 = 16'h0200; rdy0 = 1'b1;
        tick();
        redir0 = 1'b0;
        chk("ra_vld",  16'(vld0),       16'h0000);
        chk("ra_req",  16'(m0.mem_req), 16'h0001);
        chk("ra_addr", m0.mem_addr,     16'h0200);
        chk("ra_fpc",  fpc0,            16'h0200);
        tick();
        chk("ra_next_pc",   pc0,   16'h0200);
        chk("ra_next_data", data0, 16'hA7A5);

        // PC wrap and field slicing on the second instance
        do_reset();
        rst = 1'b1; en1 = 1'b1; rdy1 = 1'b1;
        tick();
        chk("wr_addr0", m1.mem_addr, 16'hFFFC);
        tick();
        chk("wr_pc0",   pc1,          16'hFFFC);
        chk("wr_data0", data1,        16'h3A50);
        chk("wr_op",    16'(op1),     16'h0003);
        chk("wr_rd",    16'(rd1),     16'h0005);
        chk("wr_rs0",   16'(rs01),    16'h0001);
        chk("wr_rs1",   16'(rs11),    16'h0002);
        chk("wr_addr1", m1.mem_addr,  16'hFFFE);
        tick();
        chk("wr_pc1",   pc1,          16'hFFFE);
        chk("wr_addr2", m1.mem_addr,  16'h0000);
        tick();
        chk("wr_pc2",   pc1,          16'h0000);
        chk("wr_data2", data1,        16'hC5AC);
        chk("wr_fpc2",  fpc1,         16'h0002);

`ifdef IFETCH_ALIGN_CHK_EN
        // Misaligned redirect halts fetch until reset
        do_reset();
        rst = 1'b1; en0 = 1'b1; rdy0 = 1'b1;
        redir0 = 1'b1; raddr0 = 16'h0011;
        tick();
        redir0 = 1'b0;
        chk("ft_fault", 16'(fault0),     16'h0001);
        chk("ft_req",   16'(m0.mem_req), 16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("ft_halt%0d_req", i), 16'(m0.mem_req), 16'h0000);
            chk($sformatf("ft_halt%0d_vld", i), 16'(vld0),       16'h0000);
        end
        rst = 1'b0;
        tick();
        chk("ft_clear", 16'(fault0), 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
